// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard peripheral: register offsets,
// STATUS/CONTROL bit positions, receiver states and a parity helper.
package ps2_pkg;

    // Register offsets inside the 32-byte window
    localparam logic [4:0] REG_DATA   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd8;
    localparam logic [4:0] REG_CTRL   = 5'd16;

    // STATUS bit positions
    localparam int ST_NOT_EMPTY   = 0;
    localparam int ST_FULL        = 1;
    localparam int ST_OVERFLOW    = 2;
    localparam int ST_ERR_FRAME   = 3;
    localparam int ST_ERR_TIMEOUT = 4;
    localparam int ST_COUNT_LSB   = 16;

    // CONTROL bit positions
    localparam int CTRL_CLEAR    = 0;
    localparam int CTRL_FLUSH    = 1;
    localparam int CTRL_IRQ_MASK = 2;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Odd parity: data plus parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, frame FSM
// and inactivity timeout. Emits one-cycle pulses for a good byte, a bad
// frame (parity or stop) and an abandoned partial frame.
module ps2_rx_frame #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_frame,
    output logic       err_timeout
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic clk_s1, clk_s2, clk_s3;
    logic dat_s1, dat_s2;
    logic fall, rx_bit, timeout_hit;

    rx_state_e state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_ok_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          good_d, bad_d;

    // Two-stage synchronisers plus a third clock stage for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= PS2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall        = clk_s3 & ~clk_s2;
    assign rx_bit      = dat_s2;
    // An arriving edge restarts the window, so it always beats the timeout
    assign timeout_hit = (state_q != IDLE) && !fall && (tmo_cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results; clocked blocks use '<=' so all registers update together.
    always_comb begin
        // NOTE: assigning a default before any branch guarantees every path
        // drives the output, which is what keeps a latch from being inferred.
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!rx_bit) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: frame verdict on the stop-bit edge
    always_comb begin
        good_d = 1'b0;
        bad_d  = 1'b0;
        if (fall && state_q == STOP) begin
            good_d = rx_bit && par_ok_q;
            bad_d  = !(rx_bit && par_ok_q);
        end
    end

    // Datapath: shift register, bit counter, parity, timeout, output pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            byte_valid  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            byte_valid  <= good_d;
            err_frame   <= bad_d;
            err_timeout <= timeout_hit;

            if (fall || state_q == IDLE || timeout_hit) tmo_cnt_q <= '0;
            else                                        tmo_cnt_q <= tmo_cnt_q + TW'(1);

            if (timeout_hit) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
                par_ok_q  <= 1'b0;
            end else if (fall) begin
                case (state_q)
                    IDLE:   bit_cnt_q <= '0;
                    DATA: begin
                        shift_q   <= {rx_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    PARITY: par_ok_q <= odd_parity_ok(shift_q, rx_bit);
                    default: ;
                endcase
            end
        end
    end

    // Shift register holds the finished byte while byte_valid pulses
    assign byte_data = shift_q;

endmodule

// File: rtl/ps2_kbd_fifo.sv
// Memory-mapped PS/2 keyboard peripheral: frame receiver, scan-code FIFO,
// sticky error flags and a DATA/STATUS/CONTROL register window.
// Optional feature macro: PS2_KBD_IRQ_EN adds a registered irq output and
// a CONTROL bit2 irq mask.
module ps2_kbd_fifo #(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    DATA_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 64'h0000_0000_0000_2000,
    parameter int                    FIFO_DEPTH     = 16,
    parameter int                    TIMEOUT_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  read,
    input  logic                  write,
    input  logic                  PS2_data,
    input  logic                  PS2_clk
`ifdef PS2_KBD_IRQ_EN
    ,
    output logic                  irq
`endif
);
    import ps2_pkg::*;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic       byte_valid, rx_err_frame, rx_err_timeout;
    logic [7:0] byte_data;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          read_q;
    logic          overflow, err_frame, err_timeout;

    logic                  hit, wr_ctrl, flush, clear;
    logic                  not_empty, full, push, pop, overflow_evt;
    logic [4:0]            offset;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bus_bits;

    ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clock       (clock),
        .reset       (reset),
        .PS2_clk     (PS2_clk),
        .PS2_data    (PS2_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .err_frame   (rx_err_frame),
        .err_timeout (rx_err_timeout)
    );

    assign hit       = address[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];
    assign offset    = address[4:0];
    assign wr_ctrl   = write && hit && (offset == REG_CTRL);
    assign flush     = wr_ctrl && data[CTRL_FLUSH];
    assign clear     = wr_ctrl && data[CTRL_CLEAR];
    assign not_empty = count != '0;
    assign full      = count == CW'(FIFO_DEPTH);
    // Pop only on the first cycle of a DATA read so a held strobe takes one byte
    assign pop          = read && hit && (offset == REG_DATA) && !read_q && not_empty;
    assign push         = byte_valid && !full;
    assign overflow_evt = byte_valid && full;

    // FIFO pointers and occupancy; flush overrides any push or pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            read_q <= 1'b0;
        end else begin
            read_q <= read;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage write
    // NOTE: the storage array has no reset; only the pointers and count need
    // one, since an entry is never read before it has been written.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= byte_data;
    end

    // Sticky flags: a new event in the same cycle as a clear leaves the flag set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow    <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            overflow    <= (overflow    && !clear) || overflow_evt;
            err_frame   <= (err_frame   && !clear) || rx_err_frame;
            err_timeout <= (err_timeout && !clear) || rx_err_timeout;
        end
    end

    // Register read mux; unmapped offsets in the window read as zero
    always_comb begin
        rd_word = '0;
        case (offset)
            REG_DATA: rd_word[7:0] = not_empty ? mem[rd_ptr] : 8'h00;
            REG_STATUS: begin
                rd_word[ST_NOT_EMPTY]        = not_empty;
                rd_word[ST_FULL]             = full;
                rd_word[ST_OVERFLOW]         = overflow;
                rd_word[ST_ERR_FRAME]        = err_frame;
                rd_word[ST_ERR_TIMEOUT]      = err_timeout;
                rd_word[ST_COUNT_LSB +: CW]  = count;
            end
            default: ;
        endcase
    end

    assign data = (read && hit) ? rd_word : 'z;

    // Upper write-data bits carry no control function
    assign unused_bus_bits = ^data[DATA_WIDTH-1:2];

`ifdef PS2_KBD_IRQ_EN
    logic irq_mask;

    // Interrupt mask register and registered interrupt request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) irq_mask <= data[CTRL_IRQ_MASK];
            irq <= !irq_mask && (not_empty || overflow || err_frame || err_timeout);
        end
    end
`endif

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Scoreboard bench for ps2_kbd_fifo: stimulus tasks queue expected bus read
// values; a monitor on the falling clock edge pops and compares them.
module tb_ps2_kbd_fifo;
    import ps2_pkg::*;

    localparam logic [63:0] BASE  = 64'h0000_0000_0000_2000;
    localparam int          TMO   = 300;
    localparam int          DEPTH = 16;
    localparam int          HALF  = 10;

    localparam logic [63:0] A_DATA   = BASE + 64'd0;
    localparam logic [63:0] A_STATUS = BASE + 64'd8;
    localparam logic [63:0] A_CTRL   = BASE + 64'd16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] address = '0;
    logic [63:0] wdata = '0;
    logic        wr_en = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        PS2_data = 1'b1;
    logic        PS2_clk = 1'b1;
    wire  [63:0] data;
`ifdef PS2_KBD_IRQ_EN
    logic        irq;
`endif

    assign data = wr_en ? wdata : 64'bz;

    ps2_kbd_fifo #(
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .BASE_ADDR      (BASE),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .data     (data),
        .read     (read),
        .write    (write),
        .PS2_data (PS2_data),
        .PS2_clk  (PS2_clk)
`ifdef PS2_KBD_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [63:0] val;
        bit          is_z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   sample_req = 1'b0;

    // Monitor: whenever a sample is presented, compare against the queue head
    always @(negedge clock) begin
        if (sample_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: got %h with no expected value queued", data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_z) begin
                    if (data !== {64{1'bz}}) begin
                        errors++;
                        $display("FAIL %s: got %h expected high-Z", mon_e.name, data);
                    end
                end else if (data !== mon_e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", mon_e.name, data, mon_e.val);
                end
            end
        end
    end

    task automatic expect_val(input string n, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        e.is_z = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic expect_z(input string n);
        exp_t e;
        e.name = n;
        e.val  = '0;
        e.is_z = 1'b1;
        exp_q.push_back(e);
    endtask

    // Read held for 'hold' cycles: first cycle expects 'first', later cycles 'rest'
    task automatic bus_read(input logic [63:0] a, input int hold,
                            input logic [63:0] first, input logic [63:0] rest,
                            input string n);
        @(posedge clock); #1;
        address = a;
        read    = 1'b1;
        for (int i = 0; i < hold; i++) begin
            expect_val(n, (i == 0) ? first : rest);
            sample_req = 1'b1;
            @(posedge clock); #1;
        end
        read       = 1'b0;
        sample_req = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] v, input string n);
        bus_read(a, 1, v, '0, n);
    endtask

    // Expect the bus to float for one cycle with the given strobe state
    task automatic probe_z(input logic [63:0] a, input logic r, input string n);
        @(posedge clock); #1;
        address = a;
        read    = r;
        expect_z(n);
        sample_req = 1'b1;
        @(posedge clock); #1;
        read       = 1'b0;
        sample_req = 1'b0;
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] v);
        @(posedge clock); #1;
        address = a;
        wdata   = v;
        wr_en   = 1'b1;
        write   = 1'b1;
        @(posedge clock); #1;
        write = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic ps2_bit(input logic b);
        PS2_data = b;
        repeat (HALF) @(posedge clock);
        #1 PS2_clk = 1'b0;
        repeat (HALF) @(posedge clock);
        #1 PS2_clk = 1'b1;
    endtask

    // Send the first nbits of a frame. With pop_at_stop, a DATA read is timed
    // so its pop lands on the same clock edge as the push of this frame.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit pop_at_stop, input logic [63:0] pop_exp);
        logic [10:0] bits;
        logic        p;
        p    = ~^b ^ bad_par;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == 10 && pop_at_stop) begin
                PS2_data = 1'b1;
                repeat (HALF) @(posedge clock);
                #1 PS2_clk = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                address = A_DATA;
                read    = 1'b1;
                expect_val("push_pop_data", pop_exp);
                sample_req = 1'b1;
                @(posedge clock); #1;
                read       = 1'b0;
                sample_req = 1'b0;
                repeat (HALF - 4) @(posedge clock);
                #1 PS2_clk = 1'b1;
            end else begin
                ps2_bit(bits[i]);
            end
        end
        PS2_data = 1'b1;
        if (nbits == 11) repeat (8) @(posedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0, '0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        probe_z(A_STATUS, 1'b0, "reset_bus_z");
        rd(A_STATUS, 64'h0, "reset_status");
        @(posedge clock); #1 reset = 1'b1;
        repeat (5) @(posedge clock);

        // Single good frame and one pop
        send(8'h1C);
        rd(A_STATUS, 64'h0001_0001, "t1_status");
        rd(A_DATA,   64'h1C,        "t1_data");
        rd(A_STATUS, 64'h0,         "t1_status_after");

        // Held read pops only once
        send(8'h1C);
        send(8'h32);
        bus_read(A_DATA, 5, 64'h1C, 64'h32, "hold_data");
        rd(A_STATUS, 64'h0001_0001, "hold_status");
        rd(A_DATA,   64'h32,        "hold_second");
        rd(A_DATA,   64'h0,         "empty_data");
        rd(A_STATUS, 64'h0,         "empty_status");

        // Bad parity sets err_frame; CONTROL clear drops it
        send_frame(8'h1C, 1'b1, 11, 1'b0, '0);
        rd(A_STATUS, 64'h8, "parity_status");
        bus_write(A_CTRL, 64'h1);
        rd(A_STATUS, 64'h0, "parity_cleared");

        // Overflow: DEPTH+1 frames
        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i));
        rd(A_STATUS, 64'h0010_0007, "full_status");
        for (int i = 1; i <= DEPTH; i++) rd(A_DATA, 64'(i), "full_drain");
        rd(A_DATA,   64'h0, "full_drain_empty");
        rd(A_STATUS, 64'h4, "overflow_sticky");
        bus_write(A_CTRL, 64'h1);
        rd(A_STATUS, 64'h0, "overflow_cleared");

        // Timeout on a partial frame, then a clean frame
        send_frame(8'hA5, 1'b0, 5, 1'b0, '0);
        repeat (TMO + 30) @(posedge clock);
        rd(A_STATUS, 64'h10, "timeout_status");
        send(8'h5A);
        rd(A_STATUS, 64'h0001_0011, "timeout_then_frame");
        rd(A_DATA,   64'h5A,        "timeout_data");
        bus_write(A_CTRL, 64'h1);
        rd(A_STATUS, 64'h0, "timeout_cleared");

        // Push and pop on the same edge with three entries queued
        send(8'h21);
        send(8'h22);
        send(8'h23);
        rd(A_STATUS, 64'h0003_0001, "pre_pushpop_status");
        send_frame(8'h24, 1'b0, 11, 1'b1, 64'h21);
        rd(A_STATUS, 64'h0003_0001, "pushpop_status");
        rd(A_DATA, 64'h22, "pushpop_order1");
        rd(A_DATA, 64'h23, "pushpop_order2");
        rd(A_DATA, 64'h24, "pushpop_order3");
        rd(A_STATUS, 64'h0, "pushpop_empty");

        // Unmapped offset, out-of-window read, and flush
        send(8'h55);
        rd(BASE + 64'd24, 64'h0, "unmapped_offset");
        probe_z(64'h3000, 1'b1, "miss_bus_z");
        bus_write(A_CTRL, 64'h2);
        rd(A_STATUS, 64'h0, "flush_status");

        // Reset mid-frame with two bytes queued
        send(8'h41);
        send(8'h42);
        rd(A_STATUS, 64'h0002_0001, "prereset_status");
        send_frame(8'h43, 1'b0, 3, 1'b0, '0);
        @(posedge clock); #1 reset = 1'b0;
        PS2_clk  = 1'b1;
        PS2_data = 1'b1;
        repeat (3) @(posedge clock);
        probe_z(A_STATUS, 1'b0, "midreset_bus_z");
        rd(A_STATUS, 64'h0, "midreset_status");
        @(posedge clock); #1 reset = 1'b1;
        repeat (5) @(posedge clock);
        send(8'h77);
        rd(A_STATUS, 64'h0001_0001, "postreset_status");
        rd(A_DATA,   64'h77,        "postreset_data");

        repeat (4) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
